// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings, FSM states
// and byte-address to word-index conversion.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extract and extend a load lane from a memory
// word, and merge sub-word store data into a memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        signed_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_word_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [4:0]  bit_shift;

  always_comb begin
    bit_shift     = {offset_i, 3'b000};
    byte_lane     = 8'(mem_word_i >> bit_shift);
    half_lane     = offset_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
    load_data_o   = mem_word_i;
    merged_word_o = store_data_i;
    case (size_i)
      SIZE_BYTE: begin
        load_data_o   = {{24{signed_i & byte_lane[7]}}, byte_lane};
        merged_word_o = (mem_word_i & ~(32'h0000_00FF << bit_shift))
                      | ({24'h0, store_data_i[7:0]} << bit_shift);
      end
      SIZE_HALF: begin
        load_data_o   = {{16{signed_i & half_lane[15]}}, half_lane};
        merged_word_o = offset_i[1] ? {store_data_i[15:0], mem_word_i[15:0]}
                                    : {mem_word_i[31:16], store_data_i[15:0]};
      end
      default: begin
        load_data_o   = mem_word_i;
        merged_word_o = store_data_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte-addressed requests, drives the word-addressed
// data memory port, and does read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        stall_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_write_data_o,
  output logic        mem_memWrite_o,
  input  logic [31:0] mem_read_data_i
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] lat_cnt;
  logic             write_q;
  logic             signed_q;
  logic [1:0]       size_q;
  logic [1:0]       offset_q;
  logic [31:0]      wdata_q;
  logic             req_err;
  logic [31:0]      load_data;
  logic [31:0]      merged_word;

  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = req_addr_i[0];
      SIZE_WORD: req_err = |req_addr_i[1:0];
      default:   req_err = 1'b1;
    endcase
    if (word_index(req_addr_i) >= 32'(MEM_WORDS)) req_err = 1'b1;
  end

  lsu_lane_align u_lane_align (
    .size_i        (size_q),
    .offset_i      (offset_q),
    .signed_i      (signed_q),
    .mem_word_i    (mem_read_data_i),
    .store_data_i  (wdata_q),
    .load_data_o   (load_data),
    .merged_word_o (merged_word)
  );

  // Memory is only ever written in WRITE, so an abort during READ of an RMW
  // leaves the target word untouched.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state            <= IDLE;
      lat_cnt          <= '0;
      write_q          <= 1'b0;
      signed_q         <= 1'b0;
      size_q           <= '0;
      offset_q         <= '0;
      wdata_q          <= '0;
      req_ready_o      <= 1'b1;
      resp_valid_o     <= 1'b0;
      resp_rdata_o     <= '0;
      resp_err_o       <= 1'b0;
      stall_o          <= 1'b0;
      mem_addr_o       <= '0;
      mem_write_data_o <= '0;
      mem_memWrite_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            write_q     <= req_write_i;
            signed_q    <= req_signed_i;
            size_q      <= req_size_i;
            offset_q    <= req_addr_i[1:0];
            wdata_q     <= req_wdata_i;
            lat_cnt     <= '0;
            req_ready_o <= 1'b0;
            stall_o     <= 1'b1;
            if (req_err) begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
            end else begin
              mem_addr_o <= word_index(req_addr_i);
              if (req_write_i && (req_size_i == SIZE_WORD)) begin
                state            <= WRITE;
                mem_write_data_o <= req_wdata_i;
                mem_memWrite_o   <= 1'b1;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          if (lat_cnt == LAT_LAST) begin
            if (write_q) begin
              state            <= WRITE;
              mem_write_data_o <= merged_word;
              mem_memWrite_o   <= 1'b1;
            end else begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b0;
              resp_rdata_o <= load_data;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        WRITE: begin
          state          <= RESP;
          mem_memWrite_o <= 1'b0;
          resp_valid_o   <= 1'b1;
          resp_err_o     <= 1'b0;
          resp_rdata_o   <= '0;
        end
        RESP: begin
          state        <= IDLE;
          resp_valid_o <= 1'b0;
          req_ready_o  <= 1'b1;
          stall_o      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against an arithmetic reference model
// with a behavioural data memory attached to the memory port.
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS   = 256;
  localparam int unsigned MEM_LATENCY = 2;

  logic        clk;
  logic        rst_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_we;
  logic [31:0] mem_read_data;

  logic [31:0] dmem    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  int checks;
  int errors;

  load_store_unit #(
    .MEM_WORDS   (MEM_WORDS),
    .MEM_LATENCY (MEM_LATENCY)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_write_i      (req_write),
    .req_size_i       (req_size),
    .req_signed_i     (req_signed),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_rdata_o     (resp_rdata),
    .resp_err_o       (resp_err),
    .stall_o          (stall),
    .mem_addr_o       (mem_addr),
    .mem_write_data_o (mem_write_data),
    .mem_memWrite_o   (mem_we),
    .mem_read_data_i  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_we && (mem_addr < MEM_WORDS)) dmem[mem_addr[7:0]] <= mem_write_data;

  assign mem_read_data = (mem_addr < MEM_WORDS) ? dmem[mem_addr[7:0]] : 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one request, from the byte-addressed access rules.
  task automatic model(input bit wr, input bit [1:0] sz, input bit sgn,
                       input bit [31:0] addr, input bit [31:0] wdata,
                       output bit err, output bit [31:0] rdata, output int lat,
                       output int wr_cnt, output bit [31:0] widx,
                       output bit [31:0] new_word);
    int unsigned nbytes;
    int unsigned off;
    longint unsigned mask;
    bit [31:0] old;
    bit [31:0] v;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    widx   = addr / 4;
    off    = addr % 4;
    mask   = (64'd1 << (8 * nbytes)) - 1;
    err    = (sz == 2'd3) || ((addr % nbytes) != 0) || (widx >= MEM_WORDS);
    rdata  = 32'h0;
    new_word = 32'h0;
    lat    = 0;
    wr_cnt = 0;
    if (!err) begin
      old = ref_mem[widx];
      if (!wr) begin
        v = 32'((longint'(old) >> (8 * off)) & mask);
        if (sgn && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~32'(mask);
        rdata    = v;
        lat      = MEM_LATENCY;
        new_word = old;
      end else begin
        new_word = (old & ~32'(mask << (8 * off))) | 32'((longint'(wdata) & mask) << (8 * off));
        lat      = (nbytes == 4) ? 1 : MEM_LATENCY + 1;
        wr_cnt   = 1;
      end
    end
  endtask

  task automatic do_req(input string tag, input bit wr, input bit [1:0] sz,
                        input bit sgn, input bit [31:0] addr, input bit [31:0] wdata);
    bit        e_err;
    bit [31:0] e_rdata;
    int        e_lat;
    int        e_wr;
    bit [31:0] widx;
    bit [31:0] new_word;
    bit        seen;
    int        lat_obs;
    int        wcnt;
    model(wr, sz, sgn, addr, wdata, e_err, e_rdata, e_lat, e_wr, widx, new_word);
    @(negedge clk);
    check_eq({tag, ".ready_idle"}, req_ready, 1'b1);
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom_range(0, 3));
    seen = 1'b0;
    lat_obs = -1;
    wcnt = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_eq({tag, ".stall_busy"}, stall, 1'b1);
        check_eq({tag, ".ready_busy"}, req_ready, 1'b0);
      end
      if (mem_we) begin
        wcnt++;
        check_eq({tag, ".wr_addr"}, mem_addr, widx);
        check_eq({tag, ".wr_data"}, mem_write_data, new_word);
      end
      if (resp_valid) begin
        seen = 1'b1;
        lat_obs = c;
      end
    end
    check_eq({tag, ".resp_seen"}, seen, 1'b1);
    check_eq({tag, ".latency"}, lat_obs, e_lat);
    check_eq({tag, ".err"}, resp_err, e_err);
    check_eq({tag, ".rdata"}, resp_rdata, e_rdata);
    check_eq({tag, ".write_cycles"}, wcnt, e_wr);
    @(negedge clk);
    check_eq({tag, ".resp_pulse"}, resp_valid, 1'b0);
    check_eq({tag, ".ready_after"}, req_ready, 1'b1);
    check_eq({tag, ".stall_after"}, stall, 1'b0);
    check_eq({tag, ".rdata_hold"}, resp_rdata, e_rdata);
    if (!e_err) begin
      if (wr) ref_mem[widx] = new_word;
      check_eq({tag, ".mem_word"}, dmem[widx[7:0]], ref_mem[widx]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".ready"}, req_ready, 1'b1);
    check_eq({tag, ".resp_valid"}, resp_valid, 1'b0);
    check_eq({tag, ".rdata"}, resp_rdata, 32'h0);
    check_eq({tag, ".err"}, resp_err, 1'b0);
    check_eq({tag, ".stall"}, stall, 1'b0);
    check_eq({tag, ".mem_addr"}, mem_addr, 32'h0);
    check_eq({tag, ".mem_wdata"}, mem_write_data, 32'h0);
    check_eq({tag, ".mem_we"}, mem_we, 1'b0);
  endtask

  initial begin
    bit seen_we;
    checks = 0;
    errors = 0;
    rst_i = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[3]    = 32'h8899AABB;
    ref_mem[3] = 32'h8899AABB;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_i = 1'b1;

    do_req("ld_word",    1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    do_req("ld_byte_s",  1'b0, 2'b00, 1'b1, 32'h0D, 32'h0);
    do_req("ld_half_u",  1'b0, 2'b01, 1'b0, 32'h0E, 32'h0);
    do_req("st_byte",    1'b1, 2'b00, 1'b0, 32'h0E, 32'h000000CC);
    do_req("ld_after_sb",1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    do_req("st_word",    1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req("ld_after_sw",1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    do_req("err_word",   1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
    do_req("err_half",   1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    do_req("err_size",   1'b1, 2'b11, 1'b0, 32'h08, 32'h12345678);
    do_req("err_range",  1'b1, 2'b00, 1'b0, 32'h400, 32'h0000005A);
    do_req("ld_top",     1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    do_req("st_half_hi", 1'b1, 2'b01, 1'b0, 32'h3FE, 32'h0000F00D);

    for (int n = 0; n < 150; n++) begin
      bit [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom);
    end

    // Abort a sub-word store while its write enable is high.
    @(negedge clk);
    req_write = 1'b1;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = 32'h21;
    req_wdata = 32'h000000E7;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen_we = 1'b0;
    for (int c = 0; c < 20 && !seen_we; c++) begin
      @(negedge clk);
      if (mem_we) seen_we = 1'b1;
    end
    check_eq("abort.saw_write", seen_we, 1'b1);
    rst_i = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    @(negedge clk);
    check_eq("abort.no_resp", resp_valid, 1'b0);
    check_eq("abort.mem_word", dmem[8], ref_mem[8]);
    rst_i = 1'b1;
    do_req("ld_after_abort", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
